// File: rtl/ae350_reset_sequencer.sv
// Reset sequencer in front of the AE350 SoC and its DDR3 controller: releases
// DDR3, POR and HW resets in order, with init-timeout retry, lock-loss recovery and warm reset.
module ae350_reset_sequencer #(
  parameter int LOCK_CYCLES  = 1024,
  parameter int POR_CYCLES   = 256,
  parameter int HW_CYCLES    = 64,
  parameter int INIT_TIMEOUT = 1048576,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pll_lock_i,
  input  logic       ddr3_init_i,
  input  logic       sw_rst_i,
  output logic       ddr3_rstn_o,
  output logic       por_rstn_o,
  output logic       hw_rstn_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam int RETRY_RAW = $clog2(MAX_RETRY + 1);
  localparam int RETRY_W   = (RETRY_RAW < 2) ? 2 : ((RETRY_RAW > 8) ? 8 : RETRY_RAW);

  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HW_LAST   = CNT_W'(HW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_LOCK_WAIT = 3'd1,
    ST_DDR_INIT  = 3'd2,
    ST_POR_HOLD  = 3'd3,
    ST_HW_HOLD   = 3'd4,
    ST_RUN       = 3'd5,
    ST_SW_RST    = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  logic [1:0] lock_sync, init_sync, sw_sync;
  logic       sw_d;
  logic       lock_s, init_s, sw_s, sw_rise;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;

  assign lock_s  = lock_sync[1];
  assign init_s  = init_sync[1];
  assign sw_s    = sw_sync[1];
  assign sw_rise = sw_s & ~sw_d;
  assign state_o = state;

  // {ddr3_rstn, por_rstn, hw_rstn, ready, fault} for a given state
  function automatic logic [4:0] decode_outs(input state_t st);
    case (st)
      ST_DDR_INIT, ST_POR_HOLD: decode_outs = 5'b10000;
      ST_HW_HOLD, ST_SW_RST:    decode_outs = 5'b11000;
      ST_RUN:                   decode_outs = 5'b11110;
      ST_FAULT:                 decode_outs = 5'b00001;
      default:                  decode_outs = 5'b00000;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    case (state)
      ST_RESET: state_nxt = ST_LOCK_WAIT;
      ST_LOCK_WAIT: begin
        if (!lock_s)                cnt_nxt   = '0;
        else if (cnt == LOCK_LAST)  state_nxt = ST_DDR_INIT;
        else                        cnt_nxt   = cnt + 1'b1;
      end
      ST_DDR_INIT: begin
        if (!lock_s)               state_nxt = ST_RESET;
        else if (init_s)           state_nxt = ST_POR_HOLD;
        else if (cnt == TO_LAST) begin
          retry_nxt = retry + 1'b1;
          state_nxt = (retry_nxt >= RETRY_MAX) ? ST_FAULT : ST_RESET;
        end else                   cnt_nxt = cnt + 1'b1;
      end
      ST_POR_HOLD: begin
        if (!lock_s || !init_s)    state_nxt = ST_RESET;
        else if (cnt == POR_LAST)  state_nxt = ST_HW_HOLD;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      ST_HW_HOLD: begin
        if (!lock_s || !init_s)    state_nxt = ST_RESET;
        else if (cnt == HW_LAST)   state_nxt = ST_RUN;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      ST_RUN: begin
        if (!lock_s || !init_s)    state_nxt = ST_RESET;
        else if (sw_rise)          state_nxt = ST_SW_RST;
      end
      ST_SW_RST: begin
        // sw_rise is deliberately ignored here so one request gives one pulse
        if (!lock_s || !init_s)    state_nxt = ST_RESET;
        else if (cnt == HW_LAST)   state_nxt = ST_RUN;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_RESET;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
    if (state_nxt == ST_RUN && state != ST_RUN) retry_nxt = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_sync   <= '0;
      init_sync   <= '0;
      sw_sync     <= '0;
      sw_d        <= 1'b0;
      state       <= ST_RESET;
      cnt         <= '0;
      retry       <= '0;
      ddr3_rstn_o <= 1'b0;
      por_rstn_o  <= 1'b0;
      hw_rstn_o   <= 1'b0;
      ready_o     <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock_i};
      init_sync <= {init_sync[0], ddr3_init_i};
      sw_sync   <= {sw_sync[0], sw_rst_i};
      sw_d      <= sw_s;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry     <= retry_nxt;
      // outputs follow the next state so they move on the same edge as state_o
      {ddr3_rstn_o, por_rstn_o, hw_rstn_o, ready_o, fault_o} <= decode_outs(state_nxt);
    end
  end

endmodule
